// File: rtl/fifo_uart_tx.sv
// Drains a first-word-fall-through FIFO and serialises each word as a UART frame
// (start, B data bits LSB first, optional even parity under UART_TX_PARITY_EN, stop).
module fifo_uart_tx #(
    parameter int unsigned B       = 8,
    parameter int unsigned DVSR    = 27,
    parameter int unsigned DVSR_W  = 5,
    parameter int unsigned SB_TICK = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         fifo_empty,
    input  logic [B-1:0] fifo_r_data,
    output logic         fifo_rd,
    output logic         tx,
    output logic         tx_busy,
    output logic         tx_done_tick
);

    localparam int unsigned N_W = (B > 1) ? $clog2(B) : 1;
    localparam int unsigned S_W = 6;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
`ifdef UART_TX_PARITY_EN
        PARITY = 3'd3,
`endif
        STOP   = 3'd4
    } state_t;

    state_t            state_reg, state_next;
    logic [DVSR_W-1:0] baud_reg, baud_next;
    logic [S_W-1:0]    s_reg, s_next;
    logic [N_W-1:0]    n_reg, n_next;
    logic [B-1:0]      b_reg, b_next;
    logic              tx_reg, tx_next;
    logic              s_tick;
`ifdef UART_TX_PARITY_EN
    logic              p_reg, p_next;
`endif

    assign s_tick  = (baud_reg == DVSR_W'(DVSR - 1));
    assign tx      = tx_reg;
    assign tx_busy = (state_reg != IDLE);

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            baud_reg  <= '0;
            s_reg     <= '0;
            n_reg     <= '0;
            b_reg     <= '0;
            tx_reg    <= 1'b1;
`ifdef UART_TX_PARITY_EN
            p_reg     <= 1'b0;
`endif
        end else begin
            state_reg <= state_next;
            baud_reg  <= baud_next;
            s_reg     <= s_next;
            n_reg     <= n_next;
            b_reg     <= b_next;
            tx_reg    <= tx_next;
`ifdef UART_TX_PARITY_EN
            p_reg     <= p_next;
`endif
        end
    end

    // Next-state, tx level one cycle ahead, FIFO pop and done strobe
    always_comb begin
        state_next   = state_reg;
        baud_next    = s_tick ? '0 : baud_reg + DVSR_W'(1);
        s_next       = s_reg;
        n_next       = n_reg;
        b_next       = b_reg;
        tx_next      = tx_reg;
`ifdef UART_TX_PARITY_EN
        p_next       = p_reg;
`endif
        fifo_rd      = 1'b0;
        tx_done_tick = 1'b0;
        case (state_reg)
            IDLE: begin
                tx_next = 1'b1;
                if (!fifo_empty && !rst) begin
                    fifo_rd    = 1'b1;
                    b_next     = fifo_r_data;
`ifdef UART_TX_PARITY_EN
                    p_next     = ^fifo_r_data;
`endif
                    baud_next  = '0;
                    s_next     = '0;
                    n_next     = '0;
                    tx_next    = 1'b0;
                    state_next = START;
                end
            end
            START: begin
                if (s_tick) begin
                    if (s_reg == S_W'(15)) begin
                        s_next     = '0;
                        tx_next    = b_reg[0];
                        state_next = DATA;
                    end else begin
                        s_next = s_reg + S_W'(1);
                    end
                end
            end
            DATA: begin
                if (s_tick) begin
                    if (s_reg == S_W'(15)) begin
                        s_next = '0;
                        b_next = b_reg >> 1;
                        if (n_reg == N_W'(B - 1)) begin
`ifdef UART_TX_PARITY_EN
                            tx_next    = p_reg;
                            state_next = PARITY;
`else
                            tx_next    = 1'b1;
                            state_next = STOP;
`endif
                        end else begin
                            n_next  = n_reg + N_W'(1);
                            tx_next = b_next[0];
                        end
                    end else begin
                        s_next = s_reg + S_W'(1);
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: begin
                if (s_tick) begin
                    if (s_reg == S_W'(15)) begin
                        s_next     = '0;
                        tx_next    = 1'b1;
                        state_next = STOP;
                    end else begin
                        s_next = s_reg + S_W'(1);
                    end
                end
            end
`endif
            STOP: begin
                if (s_tick) begin
                    if (s_reg == S_W'(SB_TICK - 1)) begin
                        tx_done_tick = 1'b1;
                        state_next   = IDLE;
                    end else begin
                        s_next = s_reg + S_W'(1);
                    end
                end
            end
            default: begin
                tx_next    = 1'b1;
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench for fifo_uart_tx with a behavioural FWFT FIFO; DVSR=4 gives a 64-cycle bit.
module tb_fifo_uart_tx;

    localparam int unsigned BIT_CYC = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_r_data = 8'h00;
    logic       fifo_rd, tx, tx_busy, tx_done_tick;

    logic [7:0] q[$];
    bit         pend = 1'b0;
    int         n_tests = 0;
    int         n_fail = 0;
    int         rd_count = 0;
    int         done_count = 0;
    int         rd_while_empty = 0;

    fifo_uart_tx #(.B(8), .DVSR(4), .DVSR_W(3), .SB_TICK(16)) dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_r_data(fifo_r_data),
        .fifo_rd(fifo_rd), .tx(tx), .tx_busy(tx_busy), .tx_done_tick(tx_done_tick)
    );

    always #5 clk = ~clk;

    // FIFO model: a pop seen before an edge takes effect shortly after that edge
    always @(negedge clk) begin
        pend = fifo_rd;
        if (fifo_rd) rd_count++;
        if (tx_done_tick) done_count++;
        if (fifo_rd && fifo_empty) rd_while_empty++;
    end

    always @(posedge clk) begin
        #2;
        if (pend && q.size() > 0) void'(q.pop_front());
        pend = 1'b0;
        fifo_empty  = (q.size() == 0);
        fifo_r_data = (q.size() > 0) ? q[0] : 8'h00;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Follows one frame from its fifo_rd cycle through the following idle cycle
    task automatic check_frame(input string tag, input logic [7:0] w, input bit at_rd,
                               input bit expect_next_rd);
        int   k;
        int   nb;
        int   ok;
        int   busy_cnt;
        int   dones;
        int   done_pos;
        int   rd_mid;
        logic exp_bits[11];
        k = 0;
        if (!at_rd) begin
            @(negedge clk);
            while (!fifo_rd && k < 5000) begin
                @(negedge clk);
                k++;
            end
        end
        check({tag, "_rd"}, 32'(fifo_rd), 32'd1);
        if (!fifo_rd) return;
        exp_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) exp_bits[i+1] = w[i];
`ifdef UART_TX_PARITY_EN
        nb = 11;
        exp_bits[9]  = ^w;
        exp_bits[10] = 1'b1;
`else
        nb = 10;
        exp_bits[9]  = 1'b1;
        exp_bits[10] = 1'b1;
`endif
        busy_cnt = 0;
        dones    = 0;
        done_pos = -1;
        rd_mid   = 0;
        for (int b = 0; b < nb; b++) begin
            ok = 0;
            for (int c = 0; c < int'(BIT_CYC); c++) begin
                @(negedge clk);
                if (tx === exp_bits[b]) ok++;
                if (tx_busy === 1'b1) busy_cnt++;
                if (fifo_rd !== 1'b0) rd_mid++;
                if (tx_done_tick === 1'b1) begin
                    dones++;
                    done_pos = b * int'(BIT_CYC) + c;
                end
            end
            check($sformatf("%s_bit%0d", tag, b), 32'(ok), BIT_CYC);
        end
        check({tag, "_busy"}, 32'(busy_cnt), 32'(nb * int'(BIT_CYC)));
        check({tag, "_ndone"}, 32'(dones), 32'd1);
        check({tag, "_donepos"}, 32'(done_pos), 32'(nb * int'(BIT_CYC) - 1));
        check({tag, "_rdmid"}, 32'(rd_mid), 32'd0);
        @(negedge clk);
        check({tag, "_idle"}, 32'({tx, tx_busy, tx_done_tick}), 32'b100);
        check({tag, "_nextrd"}, 32'(fifo_rd), 32'(expect_next_rd));
    endtask

    initial begin
        int bad;
        int rd_before;
        int done_before;

        // Reset held with data available: nothing may pop
        q.push_back(8'hA5);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("rst%0d", i), 32'({tx, fifo_rd, tx_busy, tx_done_tick}), 32'b1000);
        end
        @(posedge clk); #1;
        rst = 1'b0;

        check_frame("a5", 8'hA5, 1'b0, 1'b0);

        // Back-to-back words: stop bit stretched by exactly one idle cycle
        @(posedge clk); #1;
        q.push_back(8'h00);
        q.push_back(8'hFF);
        check_frame("w00", 8'h00, 1'b0, 1'b1);
        check_frame("wff", 8'hFF, 1'b1, 1'b0);

        // Long empty period
        rd_before = rd_count;
        bad = 0;
        for (int i = 0; i < 2000; i++) begin
            @(negedge clk);
            if (fifo_rd !== 1'b0 || tx !== 1'b1 || tx_busy !== 1'b0) bad++;
        end
        check("empty_idle", 32'(bad), 32'd0);
        check("empty_nord", 32'(rd_count - rd_before), 32'd0);

        // Reset in the middle of data bit 3 of 0x3C
        @(posedge clk); #1;
        q.push_back(8'h3C);
        bad = 0;
        @(negedge clk);
        while (!fifo_rd && bad < 5000) begin
            @(negedge clk);
            bad++;
        end
        check("w3c_rd", 32'(fifo_rd), 32'd1);
        repeat (281) @(negedge clk);
        check("w3c_midbit3", 32'({tx, tx_busy}), 32'b11);
        done_before = done_count;
        rd_before   = rd_count;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("w3c_after_rst", 32'({tx, tx_busy, tx_done_tick}), 32'b100);
        repeat (200) @(negedge clk);
        check("w3c_nodone", 32'(done_count - done_before), 32'd0);
        check("w3c_noresend", 32'(rd_count - rd_before), 32'd0);
        check("w3c_stillidle", 32'({tx, tx_busy}), 32'b10);

        @(posedge clk); #1;
        q.push_back(8'h5A);
        check_frame("w5a", 8'h5A, 1'b0, 1'b0);

`ifdef UART_TX_PARITY_EN
        @(posedge clk); #1;
        q.push_back(8'h07);
        check_frame("p07", 8'h07, 1'b0, 1'b0);
        @(posedge clk); #1;
        q.push_back(8'h03);
        check_frame("p03", 8'h03, 1'b0, 1'b0);
`endif

        check("rd_when_empty", 32'(rd_while_empty), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
